layer_sequencer: RTL and testbench

//  Initiator side of the cnn_layer load/valid interface. Takes one input tensor, runs NUM_LAYERS

---
 rtl/layer_sequencer_pkg.sv | 14 +
 rtl/layer_sequencer_if.sv | 12 +
 rtl/layer_sequencer_relu_vec.sv | 11 +
 rtl/layer_sequencer.sv | 86 ++++++++
 tb/tb_layer_sequencer.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/layer_sequencer_pkg.sv
// layer_sequencer_pkg: shared element width, cnn_layer layer codes and sequencer state encodings
package layer_sequencer_pkg;
  localparam int DATA_LEN = 16;
  localparam logic [3:0] CONV1 = 4'd1;
  localparam logic [3:0] CONV2 = 4'd2;
  localparam logic [3:0] CONV3 = 4'd3;
  localparam logic [3:0] AFFINE = 4'd8;
  localparam logic [2:0] SQ_IDLE = 3'd0;
  localparam logic [2:0] SQ_LOAD = 3'd1;
  localparam logic [2:0] SQ_WAIT = 3'd2;
  localparam logic [2:0] SQ_DRAIN = 3'd3;
  localparam logic [2:0] SQ_DONE = 3'd4;
  localparam logic [2:0] SQ_ERR = 3'd5;
endpackage

// File: rtl/layer_sequencer_if.sv
// layer_sequencer_if: load/valid link between the sequencer (master) and cnn_layer (slave)
interface layer_sequencer_if import layer_sequencer_pkg::*; #(
  parameter int N_ELEM = 384
);
  logic layer_load;
  logic [3:0] layer_cs;
  logic [N_ELEM*DATA_LEN-1:0] layer_d;
  logic layer_valid;
  logic [N_ELEM*DATA_LEN-1:0] layer_q;
  modport master (output layer_load, layer_cs, layer_d, input layer_valid, layer_q);
  modport slave (input layer_load, layer_cs, layer_d, output layer_valid, layer_q);
endinterface

// File: rtl/layer_sequencer_relu_vec.sv
// relu_vec: per-element signed clamp, negatives become zero
module relu_vec import layer_sequencer_pkg::*; #(
  parameter int N_ELEM = 384
) (
  input  logic [N_ELEM*DATA_LEN-1:0] d,
  output logic [N_ELEM*DATA_LEN-1:0] q
);
  for (genvar i = 0; i < N_ELEM; i++) begin : g_el
    assign q[i*DATA_LEN +: DATA_LEN] = d[i*DATA_LEN + DATA_LEN - 1] ? '0 : d[i*DATA_LEN +: DATA_LEN];
  end
endmodule

// File: rtl/layer_sequencer.sv
// layer_sequencer: runs NUM_LAYERS passes through one shared cnn_layer, ReLU between passes,
// raw final (AFFINE) result to q_out, with a per-pass hang watchdog
module layer_sequencer import layer_sequencer_pkg::*; #(
  parameter int NUM_LAYERS = 4,
  parameter int TIMEOUT = 4096,
  parameter int N_ELEM = 384
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic [N_ELEM*DATA_LEN-1:0] d_in,
  output logic busy,
  output logic done,
  output logic err,
  output logic [N_ELEM*DATA_LEN-1:0] q_out,
  layer_sequencer_if.master lif
);
  localparam int IW = NUM_LAYERS > 1 ? $clog2(NUM_LAYERS) : 1;
  localparam int WW = $clog2(TIMEOUT + 1);
  localparam logic [IW-1:0] LAST = IW'(NUM_LAYERS - 1);
  logic [2:0] state;
  logic [IW-1:0] idx;
  logic [WW-1:0] wdog;
  logic [N_ELEM*DATA_LEN-1:0] buffer, relu_q;
  logic last, idle;
  relu_vec #(.N_ELEM(N_ELEM)) u_relu (.d(lif.layer_q), .q(relu_q));
  assign last = idx == LAST;
  assign idle = state == SQ_IDLE || state == SQ_ERR;
  assign lif.layer_load = state == SQ_LOAD;
  assign lif.layer_cs = idle ? 4'd0 : last ? AFFINE : CONV1 + 4'(idx);
  assign lif.layer_d = buffer;
  always_ff @(posedge clk)
    if (rst) begin
      state <= SQ_IDLE;
      idx <= '0;
      wdog <= '0;
      buffer <= '0;
      q_out <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      err <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        SQ_IDLE, SQ_ERR:
          if (start) begin
            buffer <= d_in;
            idx <= '0;
            err <= 1'b0;
            busy <= 1'b1;
            state <= SQ_LOAD;
          end
        SQ_LOAD: begin
          wdog <= '0;
          state <= SQ_WAIT;
        end
        SQ_WAIT: begin
          wdog <= wdog + 1'b1;
          if (lif.layer_valid) begin
            buffer <= last ? lif.layer_q : relu_q;
            state <= SQ_DRAIN;
          end else if (wdog == WW'(TIMEOUT)) begin
            busy <= 1'b0;
            err <= 1'b1;
            state <= SQ_ERR;
          end
        end
        // valid is a level held while cnn_layer sits in FINI; reloading before it drops would be lost
        SQ_DRAIN:
          if (!lif.layer_valid) begin
            if (last) state <= SQ_DONE;
            else begin
              idx <= idx + 1'b1;
              state <= SQ_LOAD;
            end
          end
        SQ_DONE: begin
          q_out <= buffer;
          done <= 1'b1;
          busy <= 1'b0;
          state <= SQ_IDLE;
        end
        default: state <= SQ_IDLE;
      endcase
    end
endmodule

// File: tb/tb_layer_sequencer.sv
// tb_layer_sequencer: directed bench with a behavioural cnn_layer (latency 20, configurable valid hold)
module tb_layer_sequencer;
  import layer_sequencer_pkg::*;
  localparam int W = 384 * 16;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [W-1:0] d_in = '0;
  logic busy, done, err;
  logic [W-1:0] q_out;
  layer_sequencer_if #(.N_ELEM(384)) lif ();
  layer_sequencer #(.NUM_LAYERS(4), .TIMEOUT(64), .N_ELEM(384)) dut (
    .clk(clk), .rst(rst), .start(start), .d_in(d_in), .busy(busy), .done(done),
    .err(err), .q_out(q_out), .lif(lif)
  );
  always #5 clk = ~clk;
  int mode = 0, hold = 1, cnt = 0, hcnt = 0, loads = 0, cyc = 0;
  int passes = 0, fails = 0, total = 0, b = 0;
  logic m_valid = 1'b0;
  logic [W-1:0] d_cap = '0, mq;
  int load_cyc [16];
  logic [3:0] cs_log [16];
  logic [W-1:0] d_log [16];
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) begin
      cnt <= 0;
      hcnt <= 0;
      m_valid <= 1'b0;
    end else if (lif.layer_load) begin
      load_cyc[loads % 16] <= cyc;
      cs_log[loads % 16] <= lif.layer_cs;
      d_log[loads % 16] <= lif.layer_d;
      d_cap <= lif.layer_d;
      loads <= loads + 1;
      cnt <= 20;
      m_valid <= 1'b0;
    end else if (cnt != 0) begin
      cnt <= cnt - 1;
      if (cnt == 1 && mode != 2) begin
        m_valid <= 1'b1;
        hcnt <= hold;
      end
    end else if (m_valid) begin
      hcnt <= hcnt - 1;
      if (hcnt == 1) m_valid <= 1'b0;
    end
  end
  always_comb begin
    mq = '0;
    for (int i = 0; i < 384; i++)
      mq[i*16 +: 16] = mode == 1 ? (i % 2 == 1 ? 16'h0003 : 16'hFFFE) : {d_cap[i*16 +: 15], 1'b0};
  end
  assign lif.layer_q = mq;
  assign lif.layer_valid = m_valid;

  function automatic logic [W-1:0] fill(input logic [15:0] v);
    return {384{v}};
  endfunction

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    total++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed[127:0]=%h required[127:0]=%h", tag, obs[127:0], exp[127:0]);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic go(input logic [15:0] v);
    d_in = fill(v);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done();
    int k = 0;
    while (!done && k < 600) begin
      @(negedge clk);
      k++;
    end
    check("done_seen", W'(done), W'(1));
  endtask

  task automatic wait_load(input int n);
    int k = 0;
    while (loads < n && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("load_seen", W'(loads >= n), W'(1));
  endtask

  initial begin
    step(3);
    check("rst_busy", W'(busy), W'(0));
    check("rst_done", W'(done), W'(0));
    check("rst_err", W'(err), W'(0));
    check("rst_load", W'(lif.layer_load), W'(0));
    check("rst_cs", W'(lif.layer_cs), W'(0));
    check("rst_q", q_out, '0);
    rst = 1'b0;
    step(1);
    // 1: d*2 through four passes, 1 -> 16
    b = loads;
    go(16'h0001);
    check("t1_busy", W'(busy), W'(1));
    check("t1_load", W'(lif.layer_load), W'(1));
    step(6);
    check("t1_cs_wait", W'(lif.layer_cs), W'(CONV1));
    wait_done();
    check("t1_q", q_out, fill(16'h0010));
    check("t1_busy_end", W'(busy), W'(0));
    check("t1_nloads", W'(loads - b), W'(4));
    check("t1_cs0", W'(cs_log[b % 16]), W'(4'd1));
    check("t1_cs1", W'(cs_log[(b + 1) % 16]), W'(4'd2));
    check("t1_cs2", W'(cs_log[(b + 2) % 16]), W'(4'd3));
    check("t1_cs3", W'(cs_log[(b + 3) % 16]), W'(AFFINE));
    check("t1_gap", W'(load_cyc[(b + 1) % 16] - load_cyc[b % 16]), W'(23));
    step(1);
    check("t1_done_pulse", W'(done), W'(0));
    check("t1_cs_idle", W'(lif.layer_cs), W'(0));
    // 2: negative results clamped between passes, raw on the last pass
    mode = 1;
    b = loads;
    go(16'h0001);
    wait_done();
    check("t2_mid_d1", d_log[(b + 1) % 16], {192{16'h0003, 16'h0000}});
    check("t2_mid_d3", d_log[(b + 3) % 16], {192{16'h0003, 16'h0000}});
    check("t2_q_raw", q_out, {192{16'h0003, 16'hFFFE}});
    mode = 0;
    // 3: valid held 5 cycles delays the next load
    hold = 5;
    b = loads;
    go(16'h0001);
    wait_done();
    check("t3_gap01", W'(load_cyc[(b + 1) % 16] - load_cyc[b % 16]), W'(27));
    check("t3_gap23", W'(load_cyc[(b + 3) % 16] - load_cyc[(b + 2) % 16]), W'(27));
    check("t3_q", q_out, fill(16'h0010));
    hold = 1;
    // 4: no valid -> watchdog, then recovery
    mode = 2;
    b = loads;
    go(16'h0001);
    step(65);
    check("t4_err_early", W'(err), W'(0));
    step(1);
    check("t4_err", W'(err), W'(1));
    check("t4_busy", W'(busy), W'(0));
    check("t4_done", W'(done), W'(0));
    check("t4_nloads", W'(loads - b), W'(1));
    step(3);
    check("t4_err_held", W'(err), W'(1));
    check("t4_cs_err", W'(lif.layer_cs), W'(0));
    mode = 0;
    go(16'h0001);
    check("t4_err_clr", W'(err), W'(0));
    check("t4_busy_again", W'(busy), W'(1));
    wait_done();
    check("t4_q", q_out, fill(16'h0010));
    // 5: start held high mid-run and d_in changed; only the next idle start counts
    b = loads;
    d_in = fill(16'h0001);
    start = 1'b1;
    @(negedge clk);
    d_in = fill(16'h0005);
    wait_done();
    check("t5_q", q_out, fill(16'h0010));
    check("t5_nloads", W'(loads - b), W'(4));
    step(1);
    start = 1'b0;
    check("t5_restart", W'(busy), W'(1));
    wait_done();
    check("t5_q2", q_out, fill(16'h0050));
    // 6: reset in WAIT of the second pass
    b = loads;
    go(16'h0001);
    wait_load(b + 2);
    step(5);
    rst = 1'b1;
    step(1);
    check("t6_busy", W'(busy), W'(0));
    check("t6_err", W'(err), W'(0));
    check("t6_done", W'(done), W'(0));
    check("t6_load", W'(lif.layer_load), W'(0));
    check("t6_cs", W'(lif.layer_cs), W'(0));
    check("t6_q", q_out, '0);
    check("t6_d", lif.layer_d, '0);
    rst = 1'b0;
    go(16'h0001);
    wait_done();
    check("t6_q_after", q_out, fill(16'h0010));
    check("t6_nloads", W'(loads - b), W'(6));
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule
